// File: rtl/rvc_asap_pkg.sv
// Shared types for the rvc_asap_5pl D_MEM arbiter: arbiter state,
// read-data owner and the request bundle presented to D_MEM.
package rvc_asap_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ARB_NORMAL,
    ARB_LOCK
  } t_arb_state;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } t_dmem_owner;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0]   addr;
    logic [DMEM_DATA_W-1:0]   wr_data;
    logic [DMEM_DATA_W/8-1:0] byte_en;
    logic                     wr_en;
  } t_dmem_req;

endpackage

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// D_MEM port arbiter between the core's Q103H load/store and a debug master,
// with starvation protection for debug and an exclusive debug lock mode.
module rvc_asap_5pl_dmem_arb
  import rvc_asap_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                CoreReqValid,
  input  logic [ADDR_W-1:0]   CoreAddr,
  input  logic [DATA_W-1:0]   CoreWrData,
  input  logic [DATA_W/8-1:0] CoreByteEn,
  input  logic                CoreWrEn,
  output logic                CoreStall,
  output logic [DATA_W-1:0]   CoreRdData,
  input  logic                DbgReqValid,
  output logic                DbgReqReady,
  input  logic [ADDR_W-1:0]   DbgAddr,
  input  logic [DATA_W-1:0]   DbgWrData,
  input  logic [DATA_W/8-1:0] DbgByteEn,
  input  logic                DbgWrEn,
  input  logic                DbgLock,
  output logic                DbgLocked,
  output logic                DbgRspValid,
  output logic [DATA_W-1:0]   DbgRdData,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWrData,
  output logic [DATA_W/8-1:0] MemByteEn,
  output logic                MemWrEn,
  output logic                MemRdEn,
  input  logic [DATA_W-1:0]   MemRdData
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  t_arb_state        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  t_dmem_owner       owner_q, owner_d;
  logic              dbg_rsp_vld_q, dbg_rsp_vld_d;
  logic              dbg_rd_q, dbg_rd_d;

  logic      core_gnt;
  logic      dbg_gnt;
  t_dmem_req core_req;
  t_dmem_req dbg_req;
  t_dmem_req mem_req;

  assign core_req = '{addr: CoreAddr, wr_data: CoreWrData, byte_en: CoreByteEn, wr_en: CoreWrEn};
  assign dbg_req  = '{addr: DbgAddr, wr_data: DbgWrData, byte_en: DbgByteEn, wr_en: DbgWrEn};

  // Grants are forced low while reset is asserted so the port stays quiet.
  always_comb begin
    core_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    wait_cnt_d = '0;
    state_d    = DbgLock ? ARB_LOCK : ARB_NORMAL;
    if (Rst) begin
      if (state_q == ARB_LOCK) begin
        dbg_gnt = DbgReqValid;
      end else if (CoreReqValid) begin
        if (wait_cnt_q == MAX_WAIT_C && DbgReqValid) begin
          dbg_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
          if (DbgReqValid) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end else begin
        dbg_gnt = DbgReqValid;
      end
    end

    mem_req = '0;
    if (dbg_gnt)       mem_req = dbg_req;
    else if (core_gnt) mem_req = core_req;

    owner_d       = dbg_gnt ? OWN_DBG : (core_gnt ? OWN_CORE : OWN_NONE);
    dbg_rsp_vld_d = dbg_gnt;
    dbg_rd_d      = dbg_gnt & ~DbgWrEn;
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_q       <= ARB_NORMAL;
      wait_cnt_q    <= '0;
      owner_q       <= OWN_NONE;
      dbg_rsp_vld_q <= 1'b0;
      dbg_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      owner_q       <= owner_d;
      dbg_rsp_vld_q <= dbg_rsp_vld_d;
      dbg_rd_q      <= dbg_rd_d;
    end
  end

  assign MemAddr    = mem_req.addr;
  assign MemWrData  = mem_req.wr_data;
  assign MemByteEn  = mem_req.byte_en;
  assign MemWrEn    = mem_req.wr_en;
  assign MemRdEn    = (core_gnt | dbg_gnt) & ~mem_req.wr_en;

  assign CoreStall   = Rst & CoreReqValid & ~core_gnt;
  assign DbgReqReady = dbg_gnt;
  assign DbgLocked   = Rst & (state_q == ARB_LOCK);

  // Q104H return path: steer the single read-data bus to the previous owner.
  assign CoreRdData  = (Rst && owner_q == OWN_CORE) ? MemRdData : '0;
  assign DbgRspValid = Rst & dbg_rsp_vld_q;
  assign DbgRdData   = (Rst && owner_q == OWN_DBG && dbg_rd_q) ? MemRdData : '0;

endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
// Bench for rvc_asap_5pl_dmem_arb: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model of the arbiter.
module tb_rvc_asap_5pl_dmem_arb;

  localparam int MAX_WAIT = 8;
  localparam int MEM_WORDS = 4096;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        CoreReqValid, CoreWrEn, CoreStall;
  logic [31:0] CoreAddr, CoreWrData, CoreRdData;
  logic [3:0]  CoreByteEn;
  logic        DbgReqValid, DbgReqReady, DbgWrEn, DbgLock, DbgLocked, DbgRspValid;
  logic [31:0] DbgAddr, DbgWrData, DbgRdData;
  logic [3:0]  DbgByteEn;
  logic [31:0] MemAddr, MemWrData, MemRdData;
  logic [3:0]  MemByteEn;
  logic        MemWrEn, MemRdEn;

  always #5 Clock = ~Clock;

  rvc_asap_5pl_dmem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
    .CoreByteEn(CoreByteEn), .CoreWrEn(CoreWrEn), .CoreStall(CoreStall),
    .CoreRdData(CoreRdData),
    .DbgReqValid(DbgReqValid), .DbgReqReady(DbgReqReady), .DbgAddr(DbgAddr),
    .DbgWrData(DbgWrData), .DbgByteEn(DbgByteEn), .DbgWrEn(DbgWrEn),
    .DbgLock(DbgLock), .DbgLocked(DbgLocked), .DbgRspValid(DbgRspValid),
    .DbgRdData(DbgRdData),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemByteEn(MemByteEn),
    .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemRdData(MemRdData)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // D_MEM stand-in driven only by the DUT's memory port
  logic [31:0] stub_mem [MEM_WORDS];
  always @(posedge Clock) begin
    MemRdData <= MemRdEn ? stub_mem[widx(MemAddr)] : 32'h0;
    if (MemWrEn) stub_mem[widx(MemAddr)] <= merge(stub_mem[widx(MemAddr)], MemWrData, MemByteEn);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] mdl_mem [MEM_WORDS];
  bit          m_locked, m_prev_dg, m_prev_drd, m_prev_cg;
  int          m_wait;
  logic [31:0] m_rdval;
  bit          e_dg, e_cg;
  int          e_wait;

  // Values sampled in the latest cycle, for directed spot checks
  logic        s_stall, s_ready, s_locked, s_rsp, s_rden;
  logic [31:0] s_core_rd, s_dbg_rd, s_addr;

  task automatic step();
    bit          x_stall;
    logic [31:0] x_addr, x_wd, x_core_rd, x_dbg_rd;
    logic [3:0]  x_be;
    bit          x_we, x_re;
    @(negedge Clock);
    e_dg = 0; e_cg = 0; e_wait = 0; x_stall = 0;
    if (Rst) begin
      if (m_locked) begin
        e_dg = DbgReqValid;
        x_stall = CoreReqValid;
      end else if (CoreReqValid) begin
        if (m_wait >= MAX_WAIT && DbgReqValid) begin
          e_dg = 1; x_stall = 1;
        end else begin
          e_cg = 1;
          e_wait = DbgReqValid ? m_wait + 1 : 0;
        end
      end else begin
        e_dg = DbgReqValid;
      end
    end
    x_addr = 0; x_wd = 0; x_be = 0; x_we = 0; x_re = 0;
    if (e_dg) begin
      x_addr = DbgAddr; x_wd = DbgWrData; x_be = DbgByteEn; x_we = DbgWrEn; x_re = !DbgWrEn;
    end else if (e_cg) begin
      x_addr = CoreAddr; x_wd = CoreWrData; x_be = CoreByteEn; x_we = CoreWrEn; x_re = !CoreWrEn;
    end
    x_core_rd = (Rst && m_prev_cg) ? m_rdval : 32'h0;
    x_dbg_rd  = (Rst && m_prev_dg && m_prev_drd) ? m_rdval : 32'h0;

    check("CoreStall",   CoreStall,   x_stall);
    check("DbgReqReady", DbgReqReady, e_dg);
    check("DbgLocked",   DbgLocked,   Rst && m_locked);
    check("DbgRspValid", DbgRspValid, Rst && m_prev_dg);
    check("CoreRdData",  CoreRdData,  x_core_rd);
    check("DbgRdData",   DbgRdData,   x_dbg_rd);
    check("MemAddr",     MemAddr,     x_addr);
    check("MemWrData",   MemWrData,   x_wd);
    check("MemByteEn",   MemByteEn,   x_be);
    check("MemWrEn",     MemWrEn,     x_we);
    check("MemRdEn",     MemRdEn,     x_re);

    s_stall = CoreStall; s_ready = DbgReqReady; s_locked = DbgLocked; s_rsp = DbgRspValid;
    s_rden = MemRdEn; s_core_rd = CoreRdData; s_dbg_rd = DbgRdData; s_addr = MemAddr;

    @(posedge Clock);
    if (!Rst) begin
      m_locked = 0; m_wait = 0; m_prev_dg = 0; m_prev_drd = 0; m_prev_cg = 0; m_rdval = 0;
    end else begin
      m_locked   = DbgLock;
      m_wait     = e_wait;
      m_prev_dg  = e_dg;
      m_prev_drd = e_dg && !DbgWrEn;
      m_prev_cg  = e_cg;
      m_rdval    = x_re ? mdl_mem[widx(x_addr)] : 32'h0;
      if (x_we) mdl_mem[widx(x_addr)] = merge(mdl_mem[widx(x_addr)], x_wd, x_be);
    end
    #1;
  endtask

  task automatic core_set(input bit v, input logic [31:0] a, input logic [31:0] d, input bit we);
    CoreReqValid = v; CoreAddr = a; CoreWrData = d; CoreByteEn = 4'hF; CoreWrEn = we;
  endtask

  task automatic dbg_set(input bit v, input logic [31:0] a, input logic [31:0] d, input bit we);
    DbgReqValid = v; DbgAddr = a; DbgWrData = d; DbgByteEn = 4'hF; DbgWrEn = we;
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < MEM_WORDS; i++) begin
      stub_mem[i] = 32'h0;
      mdl_mem[i]  = 32'h0;
    end
    stub_mem[widx(32'h2004)] = 32'h12345678;
    mdl_mem[widx(32'h2004)]  = 32'h12345678;
    m_locked = 0; m_wait = 0; m_prev_dg = 0; m_prev_drd = 0; m_prev_cg = 0; m_rdval = 0;
    Rst = 0; DbgLock = 0;
    core_set(0, 0, 0, 0);
    dbg_set(0, 0, 0, 0);
    repeat (2) step();
    Rst = 1;
    step();

    // Core-only write then read
    core_set(1, 32'h1000, 32'hDEADBEEF, 1); step();
    check("t1_stall_wr", s_stall, 0);
    core_set(1, 32'h1000, 32'h0, 0); step();
    check("t1_stall_rd", s_stall, 0);
    core_set(0, 0, 0, 0); step();
    check("t1_core_rd", s_core_rd, 32'hDEADBEEF);

    // Debug read while the core is idle
    dbg_set(1, 32'h2004, 0, 0); step();
    check("t2_ready", s_ready, 1);
    dbg_set(0, 0, 0, 0); step();
    check("t2_rsp", s_rsp, 1);
    check("t2_rd", s_dbg_rd, 32'h12345678);

    // Starvation limit
    core_set(1, 32'h1004, 0, 0);
    dbg_set(1, 32'h1008, 0, 0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step();
      check("t3_core_wins", {s_stall, s_ready}, 2'b00);
    end
    step();
    check("t3_forced", {s_stall, s_ready}, 2'b11);
    dbg_set(0, 0, 0, 0); step();
    check("t3_regrant", {s_stall, s_rden}, 2'b01);
    check("t3_addr", s_addr, 32'h1004);
    core_set(0, 0, 0, 0);

    // Lock mode with back-to-back debug writes
    DbgLock = 1; step();
    check("t4_locked_c1", s_locked, 0);
    core_set(1, 32'h1000, 0, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      dbg_set(1, 32'h3000 + 32'(4 * i), 32'hA000 + 32'(i), 1); step();
      check("t4_locked", s_locked, 1);
      check("t4_stall", s_stall, 1);
      check("t4_ready", s_ready, 1);
      pulses += int'(s_rsp);
    end
    dbg_set(0, 0, 0, 0); DbgLock = 0; step();
    pulses += int'(s_rsp);
    check("t4_pulses", pulses, 4);
    check("t4_still_stall", s_stall, 1);
    step();
    check("t4_resume", s_stall, 0);
    core_set(0, 0, 0, 0); step();

    // Lock request coinciding with a granted core read
    core_set(1, 32'h1000, 0, 0); DbgLock = 1; step();
    check("t5_grant", s_stall, 0);
    core_set(0, 0, 0, 0); step();
    check("t5_core_rd", s_core_rd, 32'hDEADBEEF);
    check("t5_locked", s_locked, 1);
    DbgLock = 0; step();

    // Reset right after a debug read grant
    dbg_set(1, 32'h2004, 0, 0); step();
    check("t6_ready", s_ready, 1);
    Rst = 0; dbg_set(0, 0, 0, 0); step();
    check("t6_rsp_rst", s_rsp, 0);
    step();
    Rst = 1; step();
    check("t6_rsp_after", s_rsp, 0);
    check("t6_locked", s_locked, 0);

    // Random traffic obeying the handshake rules
    for (int c = 0; c < 800; c++) begin
      if (!(CoreReqValid && s_stall))
        core_set($urandom_range(3, 0) != 0, 32'h1000 + ($urandom_range(63, 0) << 2),
                 $urandom, $urandom_range(1, 0) == 1);
      if (CoreReqValid && !s_stall) CoreByteEn = 4'($urandom_range(15, 1));
      if (!(DbgReqValid && !s_ready)) begin
        dbg_set($urandom_range(2, 0) == 0, 32'h1000 + ($urandom_range(63, 0) << 2),
                $urandom, $urandom_range(1, 0) == 1);
        DbgByteEn = 4'($urandom_range(15, 1));
      end
      if ($urandom_range(39, 0) == 0) DbgLock = ~DbgLock;
      Rst = ($urandom_range(149, 0) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
